predec_queue: RTL and testbench
===============================

# predec_queue

Pre-decode stage directly downstream of instruction fetch. It accepts one 16-byte fetch packet per cycle (eight halfwords plus prediction and fault metadata) and splits it into individual RV32IC instructions, 16-bit or 32-bit. It joins 32-bit instructions that straddle two sequential packets, and buffers the results in an in-order queue that feeds decode with up to NUM_OUT instructions per cycle. It drives fetch back-pressure and is cleared on any redirect.

## Interface
- NUM_OUT, 4: instructions offered to decode per cycle.
- DEPTH, 16: queue entries; must be ≥ 8 + NUM_OUT.
- FID_W, 5: fetchID width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- IN_flush  in  1  redirect (backend or decode branch taken); clears all state.
- IN_valid  in  1  fetch packet present.
- IN_instrs  in  128  halfword i = bits [16i+15:16i].
- IN_pc  in  28  packet base; PC of halfword i is {IN_pc, i[2:0]} (31-bit halfword address).
- IN_firstValid  in  3  first valid halfword.
- IN_lastValid  in  3  last halfword that may start an instruction.
- IN_fetchID  in  FID_W  fetch ID of the packet.
- IN_fault  in  2  0 none, 1 page fault, 2 access fault, 3 interrupt.
- IN_predPos  in  3  halfword holding the last half of the predicted branch; 7 means none.
- IN_predTaken  in  1  prediction for IN_predPos.
- OUT_ready  out  1  packet is accepted this cycle if IN_valid.
- IN_outReady  in  1  decode consumes every valid output lane this cycle.
- OUT_valid[NUM_OUT]  out  1 each  lane valid.
- OUT_instr[NUM_OUT]  out  32  instruction; upper 16 bits are 0 for compressed instructions.
- OUT_pc[NUM_OUT]  out  31  halfword PC of the instruction's first halfword.
- OUT_is16[NUM_OUT]  out  1  compressed.
- OUT_fetchID[NUM_OUT]  out  FID_W.
- OUT_predTaken[NUM_OUT]  out  1.
- OUT_fault[NUM_OUT]  out  2.

## Operation
- **Accept rule.** A packet is accepted when IN_valid && OUT_ready && !IN_flush.
- **Ready.** OUT_ready = (DEPTH − count) ≥ 8, computed from the registered count. It does not depend on this cycle's dequeue. A packet yields at most 8 instructions.
- **Split.** Scan halfwords h from IN_firstValid to IN_lastValid.
  - h[1:0] ≠ 2'b11: 16-bit instruction.
  - h[1:0] = 2'b11 at index i < 7: 32-bit instruction {hw[i+1], hw[i]}. Scanning resumes at i+2, which may exceed lastValid.
  - 32-bit instruction at index 7: it goes to the carry register (halfword, PC, fetchID, carryValid = 1) and is not enqueued yet.
- **Carry join.** Applies when carryValid = 1 and the accepted packet has IN_pc == carryPC[30:3]+1, firstValid == 0, and fault == 0.
  - Emit {hw0, carryHw} first, with PC = carry PC and fetchID = carry fetchID.
  - Scanning of the new packet starts at index 1.
  - If any of the conditions fails, the carry is discarded silently.
  - The carry is cleared whenever a packet is accepted, unless that packet sets a new carry.
- **Prediction.** OUT_predTaken = IN_predTaken only for the instruction whose last halfword index equals IN_predPos (IN_predPos ≠ 7 or IN_predTaken); 0 otherwise.
- **Fault packet.** Enqueue exactly one entry: instr 0, is16 = 1, PC = {IN_pc, firstValid}, fault = IN_fault. Discard any carry.
- **Queue.** Circular buffer with read pointer, write pointer and count.
  - Enqueue n ∈ 0..8 entries in program order.
  - Lane k shows entry rd+k, valid iff k < count.
  - When IN_outReady = 1, dequeue d = min(count, NUM_OUT).
  - Enqueue and dequeue in the same cycle are allowed: count' = count + n − d. Pointers wrap modulo DEPTH.
- **Flush/reset.** count, pointers and carryValid go to 0. Any packet on IN_valid that cycle is dropped.

## Timing
- Accepted packet at edge t: its entries are visible on the outputs from cycle t+1. The path is not combinational from IN_* to OUT_*.
- Outputs are combinational from registered queue state only.
- Carry-joined instructions appear with the second packet, at t2+1.
- Flush at edge t: all OUT_valid = 0 in cycle t+1. A packet accepted at t+1 appears at t+2.
- Reset values: OUT_valid all 0; OUT_ready 1; other outputs don't-care while invalid.
- Full boundary: count = DEPTH−7 gives OUT_ready = 0, even if decode dequeues that cycle.

## Test plan
- **All-compressed packet.** Packet of 8× 0x0001, firstValid 0, lastValid 7, IN_pc 0x100, outReady 1.
  - Cycle 1: lanes 0–3 PCs 0x800–0x803, is16 = 1.
  - Cycle 2: PCs 0x804–0x807.
- **Straddling 32-bit instruction.** Packet A has hw7 = 0x0013, IN_pc 0x100; packet B has hw0 = 0x0000, IN_pc 0x101.
  - After A, no entry for halfword 7.
  - After B, first entry is instr 0x00000013, PC 0x807, fetchID of A.
  - Repeat with B IN_pc 0x200: carry is dropped, B starts at hw0.
- **Prediction.** lastValid 3, predPos 3, predTaken 1, hw2 = 0x0073, hw3 = 0x0000.
  - One 32-bit entry at PC {pc,2} with predTaken = 1.
  - Halfwords 4–7 are not enqueued.
- **Fault packet.** IN_fault 1, firstValid 5, carry pending.
  - Exactly one entry: fault 1, PC {pc,5}, instr 0.
  - Carry cleared.
- **Back-pressure.** Hold outReady 0 with compressed packets: OUT_ready drops once count ≥ 9 (DEPTH 16). Release outReady: count falls by 4 per cycle and OUT_ready returns.
- **Flush.** Flush with count 10, carry set, and IN_valid high:
  - Next cycle: all OUT_valid = 0, no carry join on the following packet.
  - rst mid-fill behaves identically.

Source files
------------

// File: rtl/predec_queue.sv
// predec_queue: pre-decode stage between instruction fetch and decode.
// Splits each 16-byte fetch packet into RV32IC instructions, joins 32-bit
// instructions that straddle two sequential packets, and buffers the result
// in an in-order circular queue that offers up to NUM_OUT entries per cycle.
module predec_queue #(
    parameter int NUM_OUT = 4,
    parameter int DEPTH   = 16,
    parameter int FID_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IN_flush,

    input  logic              IN_valid,
    input  logic [127:0]      IN_instrs,
    input  logic [27:0]       IN_pc,
    input  logic [2:0]        IN_firstValid,
    input  logic [2:0]        IN_lastValid,
    input  logic [FID_W-1:0]  IN_fetchID,
    input  logic [1:0]        IN_fault,
    input  logic [2:0]        IN_predPos,
    input  logic              IN_predTaken,
    output logic              OUT_ready,

    input  logic              IN_outReady,
    output logic              OUT_valid     [NUM_OUT],
    output logic [31:0]       OUT_instr     [NUM_OUT],
    output logic [30:0]       OUT_pc        [NUM_OUT],
    output logic              OUT_is16      [NUM_OUT],
    output logic [FID_W-1:0]  OUT_fetchID   [NUM_OUT],
    output logic              OUT_predTaken [NUM_OUT],
    output logic [1:0]        OUT_fault     [NUM_OUT]
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // One queued instruction with everything decode needs alongside it.
    typedef struct packed {
        logic [31:0]      instr;
        logic [30:0]      pc;
        logic             is16;
        logic [FID_W-1:0] fetchID;
        logic             predTaken;
        logic [1:0]       fault;
    } Entry_t;

    // Pointer advance modulo DEPTH; the offset never exceeds 8, which is
    // below DEPTH, so a single conditional subtract is enough.
    function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(DEPTH)) begin
            sum = sum - 32'(DEPTH);
        end
        return sum[PTR_W-1:0];
    endfunction

    logic [15:0]      hw [8];

    Entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;

    logic             carryValid;
    logic [15:0]      carryHw;
    logic [30:0]      carryPc;
    logic [FID_W-1:0] carryFid;

    logic             accept;
    logic             joinOk;
    logic             setCarry;
    Entry_t           newEnt [8];
    logic [3:0]       newCnt;
    logic [CNT_W-1:0] enqN;
    logic [CNT_W-1:0] deqCnt;

    // Ready only looks at the registered count so it never depends on decode
    // consuming this cycle; a packet can need up to 8 free slots.
    assign OUT_ready = (32'(count) + 32'd8 <= 32'(DEPTH));
    assign accept    = IN_valid && OUT_ready && !IN_flush && !rst;

    // The pending upper half of a straddling instruction only pairs with the
    // very next sequential packet starting at halfword 0 with no fault.
    assign joinOk = carryValid
                 && (IN_pc == carryPc[30:3] + 28'd1)
                 && (IN_firstValid == 3'd0)
                 && (IN_fault == 2'd0);

    // Unpack the fetch packet into halfwords.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            hw[i] = IN_instrs[16*i +: 16];
        end
    end

    // Split the packet into program-ordered entries and detect a new carry.
    always_comb begin
        logic skip;
        for (int j = 0; j < 8; j++) begin
            newEnt[j] = '0;
        end
        newCnt   = 4'd0;
        setCarry = 1'b0;
        skip     = 1'b0;

        if (IN_fault != 2'd0) begin
            // A faulting packet carries no usable bytes; a single marker entry
            // lets decode raise the exception at the right PC.
            newEnt[0].instr     = 32'd0;
            newEnt[0].pc        = {IN_pc, IN_firstValid};
            newEnt[0].is16      = 1'b1;
            newEnt[0].fetchID   = IN_fetchID;
            newEnt[0].predTaken = 1'b0;
            newEnt[0].fault     = IN_fault;
            newCnt              = 4'd1;
        end else begin
            if (joinOk) begin
                newEnt[0].instr     = {hw[0], carryHw};
                newEnt[0].pc        = carryPc;
                newEnt[0].is16      = 1'b0;
                newEnt[0].fetchID   = carryFid;
                newEnt[0].predTaken = IN_predTaken && (IN_predPos == 3'd0);
                newEnt[0].fault     = 2'd0;
                newCnt              = 4'd1;
            end
            for (int i = 0; i < 8; i++) begin
                if (skip) begin
                    skip = 1'b0;
                end else if ((i >= int'(IN_firstValid)) && (i <= int'(IN_lastValid))
                             && !(joinOk && (i == 0))) begin
                    if (hw[i][1:0] != 2'b11) begin
                        newEnt[newCnt[2:0]].instr     = {16'd0, hw[i]};
                        newEnt[newCnt[2:0]].pc        = {IN_pc, 3'(i)};
                        newEnt[newCnt[2:0]].is16      = 1'b1;
                        newEnt[newCnt[2:0]].fetchID   = IN_fetchID;
                        newEnt[newCnt[2:0]].predTaken = IN_predTaken && (IN_predPos == 3'(i));
                        newEnt[newCnt[2:0]].fault     = 2'd0;
                        newCnt                        = newCnt + 4'd1;
                    end else if (i < 7) begin
                        // Upper half may lie beyond lastValid; it is still
                        // part of this instruction.
                        newEnt[newCnt[2:0]].instr     = {hw[(i + 1) & 7], hw[i]};
                        newEnt[newCnt[2:0]].pc        = {IN_pc, 3'(i)};
                        newEnt[newCnt[2:0]].is16      = 1'b0;
                        newEnt[newCnt[2:0]].fetchID   = IN_fetchID;
                        newEnt[newCnt[2:0]].predTaken = IN_predTaken && (IN_predPos == 3'(i + 1));
                        newEnt[newCnt[2:0]].fault     = 2'd0;
                        newCnt                        = newCnt + 4'd1;
                        skip                          = 1'b1;
                    end else begin
                        setCarry = 1'b1;
                    end
                end
            end
        end
    end

    // Enqueue/dequeue amounts for this cycle.
    always_comb begin
        enqN = accept ? CNT_W'(newCnt) : '0;
        if (IN_outReady) begin
            deqCnt = (count < CNT_W'(NUM_OUT)) ? count : CNT_W'(NUM_OUT);
        end else begin
            deqCnt = '0;
        end
    end

    // Carry register: any accepted packet replaces or clears it.
    always_ff @(posedge clk) begin
        if (rst || IN_flush) begin
            carryValid <= 1'b0;
        end else if (accept) begin
            carryValid <= setCarry;
            if (setCarry) begin
                carryHw  <= hw[7];
                carryPc  <= {IN_pc, 3'd7};
                carryFid <= IN_fetchID;
            end
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || IN_flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            rdPtr <= wrapAdd(rdPtr, 32'(deqCnt));
            wrPtr <= wrapAdd(wrPtr, 32'(enqN));
            count <= count + enqN - deqCnt;
        end
    end

    // Queue storage; ready guarantees room for all new entries.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < 8; j++) begin
                if (j < int'(newCnt)) begin
                    mem[wrapAdd(wrPtr, 32'(j))] <= newEnt[j];
                end
            end
        end
    end

    // Present the oldest NUM_OUT entries to decode.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            OUT_valid[k]     = (int'(count) > k);
            OUT_instr[k]     = mem[wrapAdd(rdPtr, 32'(k))].instr;
            OUT_pc[k]        = mem[wrapAdd(rdPtr, 32'(k))].pc;
            OUT_is16[k]      = mem[wrapAdd(rdPtr, 32'(k))].is16;
            OUT_fetchID[k]   = mem[wrapAdd(rdPtr, 32'(k))].fetchID;
            OUT_predTaken[k] = mem[wrapAdd(rdPtr, 32'(k))].predTaken;
            OUT_fault[k]     = mem[wrapAdd(rdPtr, 32'(k))].fault;
        end
    end

endmodule

// File: tb/tb_predec_queue.sv
// Scoreboard bench for predec_queue: expected entries are queued when a
// packet is accepted; a negedge monitor compares whatever the DUT presents.
module tb_predec_queue;

    localparam int NUM_OUT = 4;
    localparam int DEPTH   = 16;
    localparam int FID_W   = 5;

    logic              clk;
    logic              rst;
    logic              IN_flush;
    logic              IN_valid;
    logic [127:0]      IN_instrs;
    logic [27:0]       IN_pc;
    logic [2:0]        IN_firstValid;
    logic [2:0]        IN_lastValid;
    logic [FID_W-1:0]  IN_fetchID;
    logic [1:0]        IN_fault;
    logic [2:0]        IN_predPos;
    logic              IN_predTaken;
    logic              OUT_ready;
    logic              IN_outReady;
    logic              OUT_valid     [NUM_OUT];
    logic [31:0]       OUT_instr     [NUM_OUT];
    logic [30:0]       OUT_pc        [NUM_OUT];
    logic              OUT_is16      [NUM_OUT];
    logic [FID_W-1:0]  OUT_fetchID   [NUM_OUT];
    logic              OUT_predTaken [NUM_OUT];
    logic [1:0]        OUT_fault     [NUM_OUT];

    predec_queue #(.NUM_OUT(NUM_OUT), .DEPTH(DEPTH), .FID_W(FID_W)) dut (
        .clk(clk), .rst(rst), .IN_flush(IN_flush),
        .IN_valid(IN_valid), .IN_instrs(IN_instrs), .IN_pc(IN_pc),
        .IN_firstValid(IN_firstValid), .IN_lastValid(IN_lastValid),
        .IN_fetchID(IN_fetchID), .IN_fault(IN_fault),
        .IN_predPos(IN_predPos), .IN_predTaken(IN_predTaken),
        .OUT_ready(OUT_ready), .IN_outReady(IN_outReady),
        .OUT_valid(OUT_valid), .OUT_instr(OUT_instr), .OUT_pc(OUT_pc),
        .OUT_is16(OUT_is16), .OUT_fetchID(OUT_fetchID),
        .OUT_predTaken(OUT_predTaken), .OUT_fault(OUT_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {instr, pc, is16, fetchID, predTaken, fault}
    logic [71:0] expQ [$];
    logic [71:0] pend [$];
    int          nChecks = 0;
    int          nPass   = 0;
    bit          monOn   = 1'b0;
    logic [15:0] hw [8];

    function automatic logic [71:0] mk(input logic [31:0] instr, input logic [30:0] pc,
                                       input logic is16, input logic [4:0] fid,
                                       input logic pred, input logic [1:0] fault);
        return {instr, pc, is16, fid, pred, fault};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fillHw(input logic [15:0] v);
        for (int i = 0; i < 8; i++) hw[i] = v;
    endtask

    task automatic drivePkt(input logic [27:0] pc, input logic [2:0] fv, input logic [2:0] lv,
                            input logic [4:0] fid, input logic [1:0] fault,
                            input logic [2:0] pp, input logic pt);
        for (int i = 0; i < 8; i++) IN_instrs[16*i +: 16] = hw[i];
        IN_pc = pc; IN_firstValid = fv; IN_lastValid = lv; IN_fetchID = fid;
        IN_fault = fault; IN_predPos = pp; IN_predTaken = pt;
        IN_valid = 1'b1;
    endtask

    // Drive a packet until accepted, then move its expectations to the scoreboard.
    task automatic sendPkt(input logic [27:0] pc, input logic [2:0] fv, input logic [2:0] lv,
                           input logic [4:0] fid, input logic [1:0] fault,
                           input logic [2:0] pp, input logic pt);
        int w;
        w = 0;
        drivePkt(pc, fv, lv, fid, fault, pp, pt);
        while (OUT_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        if (OUT_ready !== 1'b1) begin
            nChecks++;
            $display("FAIL acceptTimeout: OUT_ready=%b, expected 1", OUT_ready);
            pend.delete();
        end else begin
            @(posedge clk);
            while (pend.size() != 0) expQ.push_back(pend.pop_front());
            #1;
        end
        IN_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (expQ.size() != 0 && w < 100) begin
            tick();
            w++;
        end
        nChecks++;
        if (expQ.size() == 0) nPass++;
        else $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    endtask

    // Monitor: lane count must match the scoreboard; consumed lanes are compared.
    always @(negedge clk) begin : monitor
        int nv;
        int want;
        if (monOn) begin
            nv = 0;
            for (int k = 0; k < NUM_OUT; k++) if (OUT_valid[k] === 1'b1) nv++;
            want = (expQ.size() < NUM_OUT) ? expQ.size() : NUM_OUT;
            chk("validLanes", 72'(nv), 72'(want));
            if (IN_outReady === 1'b1) begin
                for (int k = 0; k < nv; k++) begin
                    if (expQ.size() != 0)
                        chk("entry", {OUT_instr[k], OUT_pc[k], OUT_is16[k], OUT_fetchID[k],
                                      OUT_predTaken[k], OUT_fault[k]}, expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; IN_flush = 1'b0; IN_valid = 1'b0; IN_instrs = '0; IN_pc = '0;
        IN_firstValid = 3'd0; IN_lastValid = 3'd7; IN_fetchID = '0; IN_fault = 2'd0;
        IN_predPos = 3'd7; IN_predTaken = 1'b0; IN_outReady = 1'b1;
        fillHw(16'h0001);
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("resetReady", 72'(OUT_ready), 72'd1);
        chk("resetValid", 72'({OUT_valid[0], OUT_valid[1], OUT_valid[2], OUT_valid[3]}), 72'd0);
        tick();
        monOn = 1'b1;

        // All-compressed packet
        fillHw(16'h0001);
        for (int i = 0; i < 8; i++) pend.push_back(mk(32'h1, 31'(32'h800 + i), 1'b1, 5'd1, 1'b0, 2'd0));
        sendPkt(28'h100, 3'd0, 3'd7, 5'd1, 2'd0, 3'd7, 1'b0);
        drain();

        // Straddling 32-bit instruction joined with the next sequential packet
        fillHw(16'h0001); hw[7] = 16'h0013;
        for (int i = 0; i < 7; i++) pend.push_back(mk(32'h1, 31'(32'h800 + i), 1'b1, 5'd2, 1'b0, 2'd0));
        sendPkt(28'h100, 3'd0, 3'd7, 5'd2, 2'd0, 3'd7, 1'b0);
        fillHw(16'h0001); hw[0] = 16'h0000;
        pend.push_back(mk(32'h13, 31'h807, 1'b0, 5'd2, 1'b0, 2'd0));
        for (int i = 1; i < 8; i++) pend.push_back(mk(32'h1, 31'(32'h808 + i), 1'b1, 5'd3, 1'b0, 2'd0));
        sendPkt(28'h101, 3'd0, 3'd7, 5'd3, 2'd0, 3'd7, 1'b0);
        drain();

        // Non-sequential follower drops the carry
        fillHw(16'h0001); hw[7] = 16'h0013;
        for (int i = 0; i < 7; i++) pend.push_back(mk(32'h1, 31'(32'h800 + i), 1'b1, 5'd4, 1'b0, 2'd0));
        sendPkt(28'h100, 3'd0, 3'd7, 5'd4, 2'd0, 3'd7, 1'b0);
        fillHw(16'h0001); hw[0] = 16'h0000;
        pend.push_back(mk(32'h0, 31'h1000, 1'b1, 5'd5, 1'b0, 2'd0));
        for (int i = 1; i < 8; i++) pend.push_back(mk(32'h1, 31'(32'h1000 + i), 1'b1, 5'd5, 1'b0, 2'd0));
        sendPkt(28'h200, 3'd0, 3'd7, 5'd5, 2'd0, 3'd7, 1'b0);
        drain();

        // Prediction on a 32-bit instruction ending at lastValid
        fillHw(16'h0001); hw[2] = 16'h0073; hw[3] = 16'h0000;
        pend.push_back(mk(32'h1, 31'h1800, 1'b1, 5'd6, 1'b0, 2'd0));
        pend.push_back(mk(32'h1, 31'h1801, 1'b1, 5'd6, 1'b0, 2'd0));
        pend.push_back(mk(32'h73, 31'h1802, 1'b0, 5'd6, 1'b1, 2'd0));
        sendPkt(28'h300, 3'd0, 3'd3, 5'd6, 2'd0, 3'd3, 1'b1);
        drain();

        // Fault packet discards a pending carry
        fillHw(16'h0001); hw[7] = 16'h0013;
        for (int i = 0; i < 7; i++) pend.push_back(mk(32'h1, 31'(32'h800 + i), 1'b1, 5'd7, 1'b0, 2'd0));
        sendPkt(28'h100, 3'd0, 3'd7, 5'd7, 2'd0, 3'd7, 1'b0);
        fillHw(16'h0001);
        pend.push_back(mk(32'h0, 31'h80D, 1'b1, 5'd8, 1'b0, 2'd1));
        sendPkt(28'h101, 3'd5, 3'd7, 5'd8, 2'd1, 3'd7, 1'b0);
        fillHw(16'h0001); hw[0] = 16'h0000;
        pend.push_back(mk(32'h0, 31'h808, 1'b1, 5'd9, 1'b0, 2'd0));
        for (int i = 1; i < 8; i++) pend.push_back(mk(32'h1, 31'(32'h808 + i), 1'b1, 5'd9, 1'b0, 2'd0));
        sendPkt(28'h101, 3'd0, 3'd7, 5'd9, 2'd0, 3'd7, 1'b0);
        drain();

        // Back-pressure: fill to 9 with decode stalled
        IN_outReady = 1'b0;
        fillHw(16'h0001);
        for (int i = 0; i < 5; i++) pend.push_back(mk(32'h1, 31'(32'h2000 + i), 1'b1, 5'd10, 1'b0, 2'd0));
        sendPkt(28'h400, 3'd0, 3'd4, 5'd10, 2'd0, 3'd7, 1'b0);
        for (int i = 0; i < 4; i++) pend.push_back(mk(32'h1, 31'(32'h2008 + i), 1'b1, 5'd11, 1'b0, 2'd0));
        sendPkt(28'h401, 3'd0, 3'd3, 5'd11, 2'd0, 3'd7, 1'b0);
        drivePkt(28'h402, 3'd0, 3'd7, 5'd12, 2'd0, 3'd7, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bpReadyLow", 72'(OUT_ready), 72'd0);
            tick();
        end
        IN_valid = 1'b0;
        IN_outReady = 1'b1;
        @(negedge clk);
        chk("fullBoundary", 72'(OUT_ready), 72'd0);
        tick();
        @(negedge clk);
        chk("bpReadyBack", 72'(OUT_ready), 72'd1);
        tick();
        drain();

        // Flush with count 10, carry pending and a packet on the input
        IN_outReady = 1'b0;
        fillHw(16'h0001);
        for (int i = 0; i < 3; i++) pend.push_back(mk(32'h1, 31'(32'h2000 + i), 1'b1, 5'd12, 1'b0, 2'd0));
        sendPkt(28'h400, 3'd0, 3'd2, 5'd12, 2'd0, 3'd7, 1'b0);
        hw[7] = 16'h0013;
        for (int i = 0; i < 7; i++) pend.push_back(mk(32'h1, 31'(32'h800 + i), 1'b1, 5'd13, 1'b0, 2'd0));
        sendPkt(28'h100, 3'd0, 3'd7, 5'd13, 2'd0, 3'd7, 1'b0);
        fillHw(16'h0001); hw[0] = 16'h0000;
        drivePkt(28'h101, 3'd0, 3'd7, 5'd14, 2'd0, 3'd7, 1'b0);
        IN_flush = 1'b1;
        @(posedge clk);
        expQ.delete();
        #1;
        IN_flush = 1'b0;
        IN_outReady = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NUM_OUT; k++) chk("flushValid", 72'(OUT_valid[k]), 72'd0);
        @(posedge clk);
        if (OUT_ready === 1'b1) begin
            expQ.push_back(mk(32'h0, 31'h808, 1'b1, 5'd14, 1'b0, 2'd0));
            for (int i = 1; i < 8; i++) expQ.push_back(mk(32'h1, 31'(32'h808 + i), 1'b1, 5'd14, 1'b0, 2'd0));
        end else begin
            nChecks++;
            $display("FAIL postFlushReady: OUT_ready=%b, expected 1", OUT_ready);
        end
        #1;
        IN_valid = 1'b0;
        drain();

        // Reset mid-fill with a carry pending and a packet on the input
        IN_outReady = 1'b0;
        fillHw(16'h0001); hw[7] = 16'h0013;
        for (int i = 0; i < 7; i++) pend.push_back(mk(32'h1, 31'(32'h800 + i), 1'b1, 5'd15, 1'b0, 2'd0));
        sendPkt(28'h100, 3'd0, 3'd7, 5'd15, 2'd0, 3'd7, 1'b0);
        fillHw(16'h0001); hw[0] = 16'h0000;
        drivePkt(28'h101, 3'd0, 3'd7, 5'd16, 2'd0, 3'd7, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        expQ.delete();
        #1;
        rst = 1'b0;
        IN_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NUM_OUT; k++) chk("rstValid", 72'(OUT_valid[k]), 72'd0);
        chk("rstReady", 72'(OUT_ready), 72'd1);
        IN_outReady = 1'b1;
        tick();
        pend.push_back(mk(32'h0, 31'h808, 1'b1, 5'd16, 1'b0, 2'd0));
        for (int i = 1; i < 8; i++) pend.push_back(mk(32'h1, 31'(32'h808 + i), 1'b1, 5'd16, 1'b0, 2'd0));
        sendPkt(28'h101, 3'd0, 3'd7, 5'd16, 2'd0, 3'd7, 1'b0);
        drain();

        repeat (2) tick();
        monOn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
